// File: rtl/regfile_scoreboard.sv
// Issue-side register file scoreboard.
// Tracks in-flight writes per architectural register, stalls decode on
// source or destination hazards, retires entries on writeback, and provides
// drain/flush sequencing for the control unit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, issue allowed when no hazard
// ST_DRAIN | issue blocked, waiting for all pending writes to retire
module regfile_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rs,
    input  logic [4:0]         issue_rt,
    input  logic               issue_use_rs,
    input  logic               issue_use_rt,
    input  logic [4:0]         issue_rd,
    input  logic               issue_wr,
    output logic               issue_ready,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               flush,
    input  logic               drain_req,
    output logic               drain_done,
    output logic [31:0]        busy_mask,
    output logic [STALL_W-1:0] stall_count,
    output logic               wb_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_W-1:0] STALL_ONE = 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt [32];
    logic [31:0]          w_busy;
    logic                 w_all_idle;
    logic                 w_fire;
    logic                 w_rs_hazard;
    logic                 w_rt_hazard;
    logic                 w_rd_full;
    logic                 w_issue_ready;
    logic                 w_drain_done_nxt;
    logic                 w_wb_orphan;
    logic                 r_drain_done;
    logic                 r_wb_err;
    logic [STALL_W-1:0]   r_stall;

    // Register 0 is hardwired and never tracked.
    assign w_cnt[0]  = '0;
    assign w_busy[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_fire & issue_wr & (issue_rd == 5'(gi));
            // A retire against an empty slot is an error, not an underflow.
            assign w_dec = wb_valid & (wb_rd == 5'(gi)) & (r_cnt != '0);

            // Pending-write counter: +1 on issue, -1 on writeback, cleared by flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (flush) begin
                    r_cnt <= '0;
                end else if (w_inc & ~w_dec) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end else if (w_dec & ~w_inc) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end

            assign w_cnt[gi]  = r_cnt;
            assign w_busy[gi] = (r_cnt != '0);
        end
    endgenerate

    assign w_all_idle  = (w_busy == 32'd0);
    assign w_fire      = issue_valid & w_issue_ready;
    assign w_wb_orphan = wb_valid & (wb_rd != 5'd0) & (w_cnt[wb_rd] == '0) & ~flush;

    // Hazard detection on current counters; same-cycle writeback is not bypassed.
    always_comb begin
        w_rs_hazard = issue_use_rs & (w_cnt[issue_rs] != '0);
        w_rt_hazard = issue_use_rt & (w_cnt[issue_rt] != '0);
        w_rd_full   = issue_wr & (issue_rd != 5'd0) & (w_cnt[issue_rd] == CNT_MAX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides everything and returns to RUN.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (drain_req) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_all_idle) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    // FSM outputs: issue permission and the drain-complete pulse request.
    always_comb begin
        w_issue_ready    = 1'b0;
        w_drain_done_nxt = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_issue_ready = ~w_rs_hazard & ~w_rt_hazard & ~w_rd_full;
            end
            ST_DRAIN: begin
                w_drain_done_nxt = w_all_idle & ~flush;
            end
            default: begin
                w_issue_ready    = 1'b0;
                w_drain_done_nxt = 1'b0;
            end
        endcase
    end

    // Registered one-cycle drain-complete pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_done <= 1'b0;
        end else begin
            r_drain_done <= w_drain_done_nxt;
        end
    end

    // Sticky error for writebacks with nothing pending; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_err <= 1'b0;
        end else if (w_wb_orphan) begin
            r_wb_err <= 1'b1;
        end
    end

    // Saturating count of cycles where decode presented but could not issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (issue_valid & ~w_issue_ready & (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + STALL_ONE;
        end
    end

    assign issue_ready = w_issue_ready;
    assign drain_done  = r_drain_done;
    assign busy_mask   = w_busy;
    assign stall_count = r_stall;
    assign wb_err      = r_wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed vector table, hand-written
// drain/flush/reset/saturation sequences, and randomized traffic checked
// against a counter-array reference model.
module tb_regfile_scoreboard;

    localparam int CMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic [4:0]  issue_rd;
    logic        issue_wr;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        drain_req;
    logic        drain_done;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;
    logic        wb_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.CNT_W(2), .STALL_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy_mask    (busy_mask),
        .stall_count  (stall_count),
        .wb_err       (wb_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic wr,
                         input logic wbv, input logic [4:0] wbrd,
                         input logic fl, input logic dr);
        issue_valid  = v;
        issue_rs     = rs;
        issue_use_rs = urs;
        issue_rt     = rt;
        issue_use_rt = urt;
        issue_rd     = rd;
        issue_wr     = wr;
        wb_valid     = wbv;
        wb_rd        = wbrd;
        flush        = fl;
        drain_req    = dr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy_mask, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_ready", issue_ready, 1);
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    int m_cnt [32];
    bit m_drain;
    bit m_done;
    bit m_err;
    int m_stall;

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_drain = 0;
        m_done  = 0;
        m_err   = 0;
        m_stall = 0;
    endfunction

    function automatic bit m_ready();
        if (m_drain) return 0;
        if (issue_use_rs && m_cnt[issue_rs] > 0) return 0;
        if (issue_use_rt && m_cnt[issue_rt] > 0) return 0;
        if (issue_wr && issue_rd != 0 && m_cnt[issue_rd] == CMAX) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    function automatic void m_step();
        bit rdy;
        bit allz;
        int pre;
        rdy  = m_ready();
        allz = (m_busy() == 0);
        if (issue_valid && !rdy && m_stall < 65535) m_stall++;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_drain = 0;
            m_done  = 0;
        end else begin
            m_done = m_drain && allz;
            if (m_drain && allz) m_drain = 0;
            else if (!m_drain && drain_req) m_drain = 1;
            if (wb_valid && wb_rd != 0) begin
                pre = m_cnt[wb_rd];
                if (pre == 0) m_err = 1;
                else m_cnt[wb_rd] = pre - 1;
            end
            if (issue_valid && rdy && issue_wr && issue_rd != 0) m_cnt[issue_rd]++;
        end
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic        urs;
        logic [4:0]  rt;
        logic        urt;
        logic [4:0]  rd;
        logic        wr;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        exp_ready;
        logic [31:0] exp_busy;
        logic        exp_err;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t tbl [20];

    initial begin
        rst_n = 1'b1;
        idle();

        tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 32'h000, 0, 0};
        tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'h020, 0, 0};
        tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 32'h020, 0, 1};
        tbl[3]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 32'h000, 0, 2};
        tbl[4]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h000, 0, 2};
        tbl[5]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h080, 0, 2};
        tbl[6]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h080, 0, 2};
        tbl[7]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 32'h080, 0, 2};
        tbl[8]  = '{1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 32'h080, 0, 3};
        tbl[9]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 32'h080, 0, 4};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h080, 0, 4};
        tbl[11] = '{0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 32'h080, 0, 4};
        tbl[12] = '{1, 0, 0, 0, 0, 9, 1, 1, 7, 1, 32'h080, 0, 4};
        tbl[13] = '{1, 0, 0, 0, 0, 9, 1, 1, 9, 1, 32'h280, 0, 4};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 32'h280, 0, 4};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h280, 1, 4};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 32'h280, 1, 4};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 32'h280, 1, 4};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 32'h200, 1, 4};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h000, 1, 4};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
                  tbl[i].rd, tbl[i].wr, tbl[i].wbv, tbl[i].wbrd, 0, 0);
            #1;
            chk($sformatf("tbl%0d_ready", i), issue_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_err", i), wb_err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_stall", i), stall_count, tbl[i].exp_stall);
            chk($sformatf("tbl%0d_done", i), drain_done, 0);
        end

        // Drain with two pending writes.
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); #1 chk("dr_iss2", issue_ready, 1);
        @(negedge clk); drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); #1 chk("dr_iss3", issue_ready, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("dr_req_ready", issue_ready, 1);
        chk("dr_req_busy", busy_mask, 32'h0C);
        @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 1, 2, 0, 0); #1;
        chk("dr_blk1", issue_ready, 0);
        chk("dr_done1", drain_done, 0);
        @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 1, 3, 0, 1); #1;
        chk("dr_blk2", issue_ready, 0);
        chk("dr_busy2", busy_mask, 32'h08);
        @(negedge clk); drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0); #1;
        chk("dr_blk3", issue_ready, 0);
        chk("dr_done3", drain_done, 0);
        chk("dr_busy3", busy_mask, 0);
        @(negedge clk); #1;
        chk("dr_done_pulse", drain_done, 1);
        chk("dr_resume", issue_ready, 1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0); #1;
        chk("dr_done_end", drain_done, 0);
        chk("dr_busy_after", busy_mask, 32'h10);

        // Drain with nothing pending: DRAIN at N+1, pulse and RUN at N+2.
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("dz_busy", busy_mask, 0);
        @(negedge clk); idle(); #1;
        chk("dz_n1_ready", issue_ready, 0);
        chk("dz_n1_done", drain_done, 0);
        @(negedge clk); #1;
        chk("dz_n2_done", drain_done, 1);
        chk("dz_n2_ready", issue_ready, 1);
        @(negedge clk); #1;
        chk("dz_n3_done", drain_done, 0);
        chk("dz_err", wb_err, 0);

        // Flush while draining with a pending register.
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("fl_busy0", busy_mask, 32'h40);
        @(negedge clk); drive(1, 0, 0, 0, 0, 8, 1, 1, 6, 1, 0); #1;
        chk("fl_blk", issue_ready, 0);
        @(negedge clk); idle(); #1;
        chk("fl_busy1", busy_mask, 0);
        chk("fl_ready", issue_ready, 1);
        chk("fl_done1", drain_done, 0);
        @(negedge clk); #1;
        chk("fl_done2", drain_done, 0);
        chk("fl_busy2", busy_mask, 0);

        // Reset asserted while draining.
        @(negedge clk); drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); idle(); #1;
        chk("rd_in_drain", issue_ready, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rd_ready", issue_ready, 1);
        chk("rd_busy", busy_mask, 0);
        chk("rd_done1", drain_done, 0);
        @(negedge clk); #1;
        chk("rd_done2", drain_done, 0);

        // Randomized traffic against the reference model.
        do_reset();
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            @(negedge clk);
            chk("rnd_busy", busy_mask, m_busy());
            chk("rnd_stall", stall_count, m_stall);
            chk("rnd_err", wb_err, m_err);
            chk("rnd_done", drain_done, m_done);
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_rs     = 5'($urandom_range(0, 7));
            issue_rt     = 5'($urandom_range(0, 7));
            issue_use_rs = 1'($urandom_range(0, 1));
            issue_use_rt = 1'($urandom_range(0, 1));
            issue_rd     = 5'($urandom_range(0, 7));
            issue_wr     = ($urandom_range(0, 3) != 0);
            r            = $urandom_range(0, 7);
            wb_rd        = 5'(r);
            wb_valid     = ($urandom_range(0, 1) == 1) &&
                           (m_cnt[r] > 0 || $urandom_range(0, 15) == 0);
            flush        = ($urandom_range(0, 199) == 0);
            drain_req    = ($urandom_range(0, 49) == 0);
            #1 chk("rnd_ready", issue_ready, m_ready());
            @(posedge clk);
            m_step();
        end

        // Stall counter saturation with a permanently blocked source.
        do_reset();
        @(negedge clk); drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk); drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (70000) @(negedge clk);
        #1;
        chk("sat_stall", stall_count, 16'hFFFF);
        chk("sat_ready", issue_ready, 0);
        chk("sat_busy", busy_mask, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
